// File: rtl/reg_file_mp_if.sv
// Bus bundle for the multi-port register file: three read ports, two write ports,
// pending-bit set and a synchronous clear.
interface reg_file_mp_if #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned ADDR_W = 5
);
    logic              rd_en_1;
    logic              rd_en_2;
    logic              rd_en_3;
    logic [ADDR_W-1:0] rd_addr_1;
    logic [ADDR_W-1:0] rd_addr_2;
    logic [ADDR_W-1:0] rd_addr_3;
    logic [DATA_W-1:0] rd_data_1;
    logic [DATA_W-1:0] rd_data_2;
    logic [DATA_W-1:0] rd_data_3;
    logic              rd_valid_1;
    logic              rd_valid_2;
    logic              rd_valid_3;
    logic              rd_pend_1;
    logic              rd_pend_2;
    logic              rd_pend_3;

    logic              wr_en_a;
    logic              wr_en_b;
    logic [ADDR_W-1:0] wr_addr_a;
    logic [ADDR_W-1:0] wr_addr_b;
    logic [DATA_W-1:0] wr_data_a;
    logic [DATA_W-1:0] wr_data_b;

    logic              pend_set;
    logic [ADDR_W-1:0] pend_addr;
    logic              clr;

    modport master (
        output rd_en_1, rd_en_2, rd_en_3,
        output rd_addr_1, rd_addr_2, rd_addr_3,
        input  rd_data_1, rd_data_2, rd_data_3,
        input  rd_valid_1, rd_valid_2, rd_valid_3,
        input  rd_pend_1, rd_pend_2, rd_pend_3,
        output wr_en_a, wr_en_b, wr_addr_a, wr_addr_b, wr_data_a, wr_data_b,
        output pend_set, pend_addr, clr
    );

    modport slave (
        input  rd_en_1, rd_en_2, rd_en_3,
        input  rd_addr_1, rd_addr_2, rd_addr_3,
        output rd_data_1, rd_data_2, rd_data_3,
        output rd_valid_1, rd_valid_2, rd_valid_3,
        output rd_pend_1, rd_pend_2, rd_pend_3,
        input  wr_en_a, wr_en_b, wr_addr_a, wr_addr_b, wr_data_a, wr_data_b,
        input  pend_set, pend_addr, clr
    );
endinterface

// File: rtl/reg_file_mp.sv
// Three-read / two-write register file with per-entry pending scoreboard bits,
// registered reads with same-cycle write-through bypass, and optional hardwired entry 0.
module reg_file_mp #(
    parameter int unsigned DATA_W   = 16,
    parameter int unsigned ADDR_W   = 5,
    parameter bit          ZERO_REG = 1'b0
) (
    input logic          clk,
    input logic          rst_n,
    reg_file_mp_if.slave bus
);
    localparam int unsigned DEPTH  = 2 ** ADDR_W;
    localparam int unsigned NUM_RD = 3;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] mem_d [DEPTH];
    logic [DEPTH-1:0]  pend_q;
    logic [DEPTH-1:0]  pend_d;

    logic [DEPTH-1:0]  hit_a;
    logic [DEPTH-1:0]  hit_b;
    logic [DEPTH-1:0]  hit_p;

    logic [NUM_RD-1:0] rd_en;
    logic [ADDR_W-1:0] rd_addr [NUM_RD];
    logic [DATA_W-1:0] rd_data_q [NUM_RD];
    logic [DATA_W-1:0] rd_data_d [NUM_RD];
    logic [NUM_RD-1:0] rd_pend_q;
    logic [NUM_RD-1:0] rd_pend_d;
    logic [NUM_RD-1:0] rd_valid_q;

    assign rd_en      = {bus.rd_en_3, bus.rd_en_2, bus.rd_en_1};
    assign rd_addr[0] = bus.rd_addr_1;
    assign rd_addr[1] = bus.rd_addr_2;
    assign rd_addr[2] = bus.rd_addr_3;

    assign bus.rd_data_1  = rd_data_q[0];
    assign bus.rd_data_2  = rd_data_q[1];
    assign bus.rd_data_3  = rd_data_q[2];
    assign bus.rd_pend_1  = rd_pend_q[0];
    assign bus.rd_pend_2  = rd_pend_q[1];
    assign bus.rd_pend_3  = rd_pend_q[2];
    assign bus.rd_valid_1 = rd_valid_q[0];
    assign bus.rd_valid_2 = rd_valid_q[1];
    assign bus.rd_valid_3 = rd_valid_q[2];

    // Per-entry strobes; entry 0 is masked off entirely when it is hardwired.
    always_comb begin
        hit_a = '0;
        hit_b = '0;
        hit_p = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (!(ZERO_REG && i == 0)) begin
                hit_a[i] = bus.wr_en_a  && (bus.wr_addr_a == ADDR_W'(i));
                hit_b[i] = bus.wr_en_b  && (bus.wr_addr_b == ADDR_W'(i));
                hit_p[i] = bus.pend_set && (bus.pend_addr == ADDR_W'(i));
            end
        end
    end

    // Next-state of every entry; reads sample this, which yields the bypass for free.
    always_comb begin
        pend_d = pend_q;
        for (int i = 0; i < DEPTH; i++) begin
            mem_d[i] = mem_q[i];
            if (bus.clr) begin
                mem_d[i]  = '0;
                pend_d[i] = 1'b0;
            end else begin
                if (hit_b[i]) begin
                    mem_d[i] = bus.wr_data_b;
                end else if (hit_a[i]) begin
                    mem_d[i] = bus.wr_data_a;
                end
                if (hit_p[i]) begin
                    pend_d[i] = 1'b1;
                end else if (hit_a[i] || hit_b[i]) begin
                    pend_d[i] = 1'b0;
                end
            end
        end
    end

    always_comb begin
        for (int p = 0; p < NUM_RD; p++) begin
            rd_data_d[p] = rd_data_q[p];
            rd_pend_d[p] = rd_pend_q[p];
            if (rd_en[p]) begin
                rd_data_d[p] = mem_d[rd_addr[p]];
                rd_pend_d[p] = pend_d[rd_addr[p]];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            pend_q <= '0;
        end else begin
            mem_q  <= mem_d;
            pend_q <= pend_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int p = 0; p < NUM_RD; p++) begin
                rd_data_q[p] <= '0;
            end
            rd_pend_q  <= '0;
            rd_valid_q <= '0;
        end else begin
            rd_data_q  <= rd_data_d;
            rd_pend_q  <= rd_pend_d;
            rd_valid_q <= rd_en;
        end
    end

endmodule

// File: tb/tb_reg_file_mp.sv
// Scoreboard bench: two DUTs (ZERO_REG=0 and 1) share stimulus; a sequential array model
// predicts each read, and a monitor pops predictions whenever rd_valid is seen.
module tb_reg_file_mp;
    localparam int unsigned DW = 16;
    localparam int unsigned AW = 5;
    localparam int unsigned N  = 2 ** AW;

    typedef struct packed {
        logic [DW-1:0] d;
        logic          p;
    } exp_t;

    logic clk;
    logic rst_n;

    logic [2:0]    rd_en;
    logic [AW-1:0] rd_addr [3];
    logic          wr_en_a, wr_en_b;
    logic [AW-1:0] wr_addr_a, wr_addr_b;
    logic [DW-1:0] wr_data_a, wr_data_b;
    logic          pend_set;
    logic [AW-1:0] pend_addr;
    logic          clr;

    logic [2:0]    vld_a [2];
    logic [2:0]    pnd_a [2];
    logic [DW-1:0] dat_a [2][3];

    logic [DW-1:0] m_mem  [2][N];
    logic          m_pend [2][N];
    exp_t          exp_q  [2][3][$];
    exp_t          last_e [2][3];

    int total;
    int bad;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        reg_file_mp_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

        reg_file_mp #(.DATA_W(DW), .ADDR_W(AW), .ZERO_REG(g == 1)) dut (
            .clk   (clk),
            .rst_n (rst_n),
            .bus   (bus)
        );

        assign bus.rd_en_1   = rd_en[0];
        assign bus.rd_en_2   = rd_en[1];
        assign bus.rd_en_3   = rd_en[2];
        assign bus.rd_addr_1 = rd_addr[0];
        assign bus.rd_addr_2 = rd_addr[1];
        assign bus.rd_addr_3 = rd_addr[2];
        assign bus.wr_en_a   = wr_en_a;
        assign bus.wr_en_b   = wr_en_b;
        assign bus.wr_addr_a = wr_addr_a;
        assign bus.wr_addr_b = wr_addr_b;
        assign bus.wr_data_a = wr_data_a;
        assign bus.wr_data_b = wr_data_b;
        assign bus.pend_set  = pend_set;
        assign bus.pend_addr = pend_addr;
        assign bus.clr       = clr;

        assign vld_a[g]    = {bus.rd_valid_3, bus.rd_valid_2, bus.rd_valid_1};
        assign pnd_a[g]    = {bus.rd_pend_3, bus.rd_pend_2, bus.rd_pend_1};
        assign dat_a[g][0] = bus.rd_data_1;
        assign dat_a[g][1] = bus.rd_data_2;
        assign dat_a[g][2] = bus.rd_data_3;
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic idle();
        rd_en     = '0;
        wr_en_a   = 1'b0;
        wr_en_b   = 1'b0;
        wr_addr_a = '0;
        wr_addr_b = '0;
        wr_data_a = '0;
        wr_data_b = '0;
        pend_set  = 1'b0;
        pend_addr = '0;
        clr       = 1'b0;
        for (int p = 0; p < 3; p++) rd_addr[p] = '0;
    endtask

    task automatic model_clear();
        for (int g = 0; g < 2; g++) begin
            for (int i = 0; i < N; i++) begin
                m_mem[g][i]  = '0;
                m_pend[g][i] = 1'b0;
            end
            for (int p = 0; p < 3; p++) begin
                exp_q[g][p].delete();
                last_e[g][p] = '0;
            end
        end
    endtask

    // Apply this cycle's operations in program order, then predict every enabled read.
    task automatic model_step();
        exp_t e;
        for (int g = 0; g < 2; g++) begin
            if (clr) begin
                for (int i = 0; i < N; i++) begin
                    m_mem[g][i]  = '0;
                    m_pend[g][i] = 1'b0;
                end
            end else begin
                if (wr_en_a) begin
                    m_mem[g][wr_addr_a]  = wr_data_a;
                    m_pend[g][wr_addr_a] = 1'b0;
                end
                if (wr_en_b) begin
                    m_mem[g][wr_addr_b]  = wr_data_b;
                    m_pend[g][wr_addr_b] = 1'b0;
                end
                if (pend_set) m_pend[g][pend_addr] = 1'b1;
                if (g == 1) begin
                    m_mem[g][0]  = '0;
                    m_pend[g][0] = 1'b0;
                end
            end
            for (int p = 0; p < 3; p++) begin
                if (rd_en[p]) begin
                    e.d = m_mem[g][rd_addr[p]];
                    e.p = m_pend[g][rd_addr[p]];
                    exp_q[g][p].push_back(e);
                end
            end
        end
    endtask

    task automatic tick();
        model_step();
        @(negedge clk);
    endtask

    task automatic check_reset_zero(input string tag);
        for (int g = 0; g < 2; g++) begin
            for (int p = 0; p < 3; p++) begin
                total++;
                if (vld_a[g][p] !== 1'b0 || pnd_a[g][p] !== 1'b0 || dat_a[g][p] !== '0) begin
                    bad++;
                    $display("FAIL %s dut%0d port%0d: got valid=%b data=%h pend=%b, want all 0",
                             tag, g, p, vld_a[g][p], dat_a[g][p], pnd_a[g][p]);
                end
            end
        end
    endtask

    // Inputs already driven for this cycle; reset hits before the capturing edge.
    task automatic mid_reset();
        #3 rst_n = 1'b0;
        #1 check_reset_zero("mid_reset");
        model_clear();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    function automatic logic [AW-1:0] rnd_addr();
        if ($urandom_range(0, 1) == 0) return AW'($urandom_range(0, 3));
        return AW'($urandom_range(0, N - 1));
    endfunction

    task automatic rand_inputs();
        for (int p = 0; p < 3; p++) begin
            rd_en[p]   = 1'($urandom_range(0, 1));
            rd_addr[p] = rnd_addr();
        end
        wr_en_a   = 1'($urandom_range(0, 1));
        wr_en_b   = 1'($urandom_range(0, 1));
        wr_addr_a = rnd_addr();
        wr_addr_b = rnd_addr();
        wr_data_a = DW'($urandom);
        wr_data_b = DW'($urandom);
        pend_set  = ($urandom_range(0, 2) == 0);
        pend_addr = rnd_addr();
        clr       = ($urandom_range(0, 59) == 0);
    endtask

    // Monitor: one check per port per cycle, 2 time units after the active edge.
    always begin
        exp_t e;
        @(posedge clk);
        #2;
        if (rst_n) begin
            for (int g = 0; g < 2; g++) begin
                for (int p = 0; p < 3; p++) begin
                    total++;
                    if (vld_a[g][p]) begin
                        if (exp_q[g][p].size() == 0) begin
                            bad++;
                            $display("FAIL spurious_valid dut%0d port%0d: got valid=1 data=%h, want valid=0",
                                     g, p, dat_a[g][p]);
                        end else begin
                            e = exp_q[g][p].pop_front();
                            last_e[g][p] = e;
                            if (dat_a[g][p] !== e.d || pnd_a[g][p] !== e.p) begin
                                bad++;
                                $display("FAIL read dut%0d port%0d: got data=%h pend=%b, want data=%h pend=%b",
                                         g, p, dat_a[g][p], pnd_a[g][p], e.d, e.p);
                            end
                        end
                    end else if (exp_q[g][p].size() != 0) begin
                        e = exp_q[g][p].pop_front();
                        bad++;
                        $display("FAIL missing_valid dut%0d port%0d: got valid=0, want valid=1 data=%h",
                                 g, p, e.d);
                    end else if (dat_a[g][p] !== last_e[g][p].d || pnd_a[g][p] !== last_e[g][p].p) begin
                        bad++;
                        $display("FAIL hold dut%0d port%0d: got data=%h pend=%b, want data=%h pend=%b",
                                 g, p, dat_a[g][p], pnd_a[g][p], last_e[g][p].d, last_e[g][p].p);
                    end
                end
            end
        end
    end

    initial begin
        total = 0;
        bad   = 0;
        idle();
        model_clear();
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #2 check_reset_zero("por");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Write then read back on port 1.
        idle(); wr_en_a = 1'b1; wr_addr_a = 3; wr_data_a = 16'h1234; tick();
        idle(); rd_en[0] = 1'b1; rd_addr[0] = 3; tick();

        // Same-address A/B collision with same-cycle read, then re-read.
        idle();
        wr_en_a = 1'b1; wr_addr_a = 7; wr_data_a = 16'hAAAA;
        wr_en_b = 1'b1; wr_addr_b = 7; wr_data_b = 16'h5555;
        rd_en[1] = 1'b1; rd_addr[1] = 7;
        tick();
        idle(); rd_en = 3'b111; for (int p = 0; p < 3; p++) rd_addr[p] = 7; tick();

        // Pending set, read, then write clears it with bypassed read.
        idle(); pend_set = 1'b1; pend_addr = 9; tick();
        idle(); rd_en[2] = 1'b1; rd_addr[2] = 9; tick();
        idle(); wr_en_a = 1'b1; wr_addr_a = 9; wr_data_a = 16'h0042;
        rd_en[0] = 1'b1; rd_addr[0] = 9; tick();

        // Entry 0: write + pend_set, with same-cycle and later reads on all ports.
        idle(); wr_en_b = 1'b1; wr_addr_b = 0; wr_data_b = 16'hFFFF;
        pend_set = 1'b1; pend_addr = 0; rd_en[1] = 1'b1; rd_addr[1] = 0; tick();
        idle(); rd_en = 3'b111; for (int p = 0; p < 3; p++) rd_addr[p] = 0; tick();

        // Fill, then clear against a same-cycle write and pend_set.
        for (int i = 0; i < N; i++) begin
            idle(); wr_en_a = 1'b1; wr_addr_a = AW'(i); wr_data_a = DW'(i);
            pend_set = (i % 2 == 1); pend_addr = AW'(i); tick();
        end
        idle(); clr = 1'b1; wr_en_a = 1'b1; wr_addr_a = 5; wr_data_a = 16'h7777;
        pend_set = 1'b1; pend_addr = 6; rd_en = 3'b111;
        rd_addr[0] = 5; rd_addr[1] = 6; rd_addr[2] = 1; tick();
        for (int i = 0; i < N; i += 3) begin
            idle(); rd_en = 3'b111;
            for (int p = 0; p < 3; p++) rd_addr[p] = AW'((i + p) % N);
            tick();
        end

        // Reset between a read request and its result.
        idle(); wr_en_a = 1'b1; wr_addr_a = 12; wr_data_a = 16'hBEEF; tick();
        idle(); rd_en = 3'b111; for (int p = 0; p < 3; p++) rd_addr[p] = 12;
        mid_reset();
        idle(); tick();
        idle(); rd_en[0] = 1'b1; rd_addr[0] = 12; tick();

        repeat (3000) begin
            rand_inputs();
            tick();
        end

        idle(); tick(); tick();
        for (int g = 0; g < 2; g++) begin
            for (int p = 0; p < 3; p++) begin
                total++;
                if (exp_q[g][p].size() != 0) begin
                    bad++;
                    $display("FAIL drain dut%0d port%0d: got %0d outstanding reads, want 0",
                             g, p, exp_q[g][p].size());
                end
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/reg_file_mp.md
REG_FILE_MP -- requirements
Module: reg_file_mp

Interface
REQ-001 SHALL provide parameter DATA_W, default 16, meaning the register width in bits.
REQ-002 SHALL provide parameter ADDR_W, default 5, meaning the address width; depth is 2**ADDR_W entries.
REQ-003 SHALL provide parameter ZERO_REG, default 0, where 1 makes entry 0 hardwired to zero.
REQ-004 SHALL have one clock and an asynchronous, active-low reset: clk  in  1  rising-edge clock.
REQ-005 rst_n  in  1  asynchronous active-low reset.
REQ-006 rd_en_1/2/3  in  1 each  read request per port.
REQ-007 rd_addr_1/2/3  in  ADDR_W each  read address per port.
REQ-008 rd_data_1/2/3  out  DATA_W each  registered read data.
REQ-009 rd_valid_1/2/3  out  1 each  rd_data_n updated this cycle.
REQ-010 rd_pend_1/2/3  out  1 each  pending (scoreboard) bit of the entry read.
REQ-011 wr_en_a, wr_en_b  in  1 each  write strobes, ports A and B.
REQ-012 wr_addr_a, wr_addr_b  in  ADDR_W each  write addresses.
REQ-013 wr_data_a, wr_data_b  in  DATA_W each  write data.
REQ-014 pend_set  in  1  mark entry pend_addr as pending.
REQ-015 pend_addr  in  ADDR_W  entry to mark pending.
REQ-016 clr  in  1  synchronous clear of all entries and pending bits.

Function
REQ-017 Writes SHALL commit on the rising clk edge where the strobe is high; two writes to different addresses both commit.
REQ-018 Same-address writes on A and B in one cycle SHALL commit wr_data_b (B has priority).
REQ-019 Reads SHALL have 1-cycle latency: rd_en_n high at edge t loads rd_data_n with the entry value after edge t's writes (write-through bypass, priority B > A > stored value).
REQ-020 rd_valid_n SHALL be rd_en_n delayed one cycle; rd_data_n and rd_pend_n hold their last values when rd_en_n is low.
REQ-021 All three read ports SHALL operate independently and may read the same address in the same cycle.
REQ-022 Pending bits: pend_set at edge t sets bit[pend_addr]; a write to an entry clears its bit; pend_set and write to the same address in one cycle leave the bit set.
REQ-023 rd_pend_n SHALL reflect the pending bit after edge t's set/clear updates, registered alongside rd_data_n.
REQ-024 With ZERO_REG=1, writes and pend_set to entry 0 SHALL be ignored, and reads of entry 0 SHALL return data 0 and pend 0, bypass included.
REQ-025 clr at edge t SHALL zero every entry and every pending bit, overriding same-cycle writes and pend_set; reads issued at t return 0 with pend 0, rd_valid still asserted.
REQ-026 No combinational path SHALL exist from any input to any output.

Reset
REQ-027 While rst_n is low, all entries, pending bits, rd_data_n, rd_pend_n and rd_valid_n SHALL be 0, asynchronously to clk.
REQ-028 After rst_n deasserts, the first rising edge SHALL be a normal operating edge.
REQ-029 An rst_n assertion mid-operation SHALL discard any in-flight read result; rd_valid_n is 0 in the next cycle.

Verification
REQ-030 Write A addr 3 = 0x1234; next cycle read port 1 addr 3 -> rd_data_1 = 0x1234 and rd_valid_1 = 1 one cycle later.
REQ-031 Same cycle: wr_en_a addr 7 = 0xAAAA, wr_en_b addr 7 = 0x5555, rd_en_2 addr 7 -> rd_data_2 = 0x5555 next cycle; a later read also returns 0x5555.
REQ-032 pend_set addr 9, then read addr 9 -> rd_pend = 1; write A addr 9 = 0x0042 with same-cycle read -> rd_data = 0x0042, rd_pend = 0.
REQ-033 ZERO_REG=1: write B addr 0 = 0xFFFF plus pend_set addr 0, then read addr 0 on all ports -> data 0x0000, pend 0.
REQ-034 Fill entries 0..31 with their index, pulse clr with a same-cycle write addr 5 = 0x7777 -> every read returns 0x0000.
REQ-035 Assert rst_n low between a read request and its result -> rd_valid 0, rd_data 0; the stored entry reads 0 after reset.
